sha1_msg_padder: RTL and testbench

//  Upstream stage of the SHA-1 round core. Accepts a message as a stream of
//  big-endian 32-bit words and emits the FIPS 180 padded stream one word per beat.

---
 rtl/sha1_msg_padder.sv | 189 ++++++++++++++++++
 tb/tb_sha1_msg_padder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder: turns a stream of big-endian 32-bit message words into the
// SHA-1 padded word stream (0x80 marker, zero fill, 64-bit bit length), one word
// per beat, grouped into 16-word blocks for the round core.
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   in_data/in_valid/in_ready      message word input handshake
//   in_last/in_bytes               final-word marker and valid byte count (0..4)
//   out_data/out_valid/out_ready   padded word output handshake (single register)
//   out_first/out_blk_last         word 0 / word 15 of a block
//   out_msg_last                   word 15 of the final block of the message
//   busy                           message in progress or output pending
module sha1_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StPad,
        StZero,
        StLenHi,
        StLenLo
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       widx_q, widx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             blk_last_q, blk_last_d;
    logic             msg_last_q, msg_last_d;

    logic        slot_free;
    logic        accept_ok;
    logic        load;
    logic        load_msg_last;
    logic [31:0] load_word;
    logic [2:0]  nbytes;
    logic [31:0] pad_word;
    logic [63:0] len_ext;

    assign slot_free = !valid_q || out_ready;
    assign accept_ok = (state_q == StIdle) || (state_q == StData);
    assign in_ready  = slot_free && accept_ok;
    assign len_ext   = 64'(len_q);

    // Oversized in_bytes on the last word behaves like a full word.
    assign nbytes = (in_last && (in_bytes < 3'd4)) ? in_bytes : 3'd4;

    // Partial last word: keep the valid leading bytes, marker byte right after them.
    always_comb begin
        pad_word = 32'h8000_0000;
        unique case (in_bytes[1:0])
            2'd0: pad_word = 32'h8000_0000;
            2'd1: pad_word = {in_data[31:24], 24'h80_0000};
            2'd2: pad_word = {in_data[31:16], 16'h8000};
            2'd3: pad_word = {in_data[31:8], 8'h80};
            default: pad_word = 32'h8000_0000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        len_d         = len_q;
        data_d        = data_q;
        valid_d       = valid_q;
        first_d       = first_q;
        blk_last_d    = blk_last_q;
        msg_last_d    = msg_last_q;
        load          = 1'b0;
        load_word     = 32'h0;
        load_msg_last = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StData: begin
                if (in_valid && slot_free) begin
                    load  = 1'b1;
                    len_d = len_q + LEN_W'({nbytes, 3'b000});
                    if (!in_last) begin
                        load_word = in_data;
                        state_d   = StData;
                    end else if (nbytes == 3'd4) begin
                        load_word = in_data;
                        state_d   = StPad;
                    end else begin
                        load_word = pad_word;
                        state_d   = StZero;
                    end
                end
            end
            StPad: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = 32'h8000_0000;
                    state_d   = StZero;
                end
            end
            StZero: begin
                // Index 14 is reserved for the length; move on without loading.
                if (slot_free) begin
                    if (widx_q == 4'd14) begin
                        state_d = StLenHi;
                    end else begin
                        load      = 1'b1;
                        load_word = 32'h0;
                    end
                end
            end
            StLenHi: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = len_ext[63:32];
                    state_d   = StLenLo;
                end
            end
            StLenLo: begin
                if (slot_free) begin
                    load          = 1'b1;
                    load_word     = len_ext[31:0];
                    load_msg_last = 1'b1;
                    len_d         = '0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            data_d     = load_word;
            valid_d    = 1'b1;
            first_d    = (widx_q == 4'd0);
            blk_last_d = (widx_q == 4'd15);
            msg_last_d = load_msg_last;
            widx_d     = widx_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            widx_q     <= 4'd0;
            len_q      <= '0;
            data_q     <= 32'h0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            blk_last_q <= 1'b0;
            msg_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            blk_last_q <= blk_last_d;
            msg_last_q <= msg_last_d;
        end
    end

    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign out_first    = first_q;
    assign out_blk_last = blk_last_q;
    assign out_msg_last = msg_last_q;
    assign busy         = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: random messages against a byte-level FIPS padding model.
module tb_sha1_msg_padder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes = 3'd0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;
    logic        busy;

    sha1_msg_padder #(.LEN_W(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        blk;
        logic        msg;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_pct = 100;

    beat_t       exp_q[$];
    logic [7:0]  msg_bytes[$];
    logic [31:0] log_q[$];
    int          msg_words = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // FIPS 180 padding of a byte string, regrouped into big-endian words.
    function automatic wq_t pad_msg(input bq_t m);
        bq_t             b;
        wq_t             w;
        longint unsigned bits;
        b    = m;
        bits = 64'(m.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
        for (int i = 0; i < b.size(); i += 4) w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
        return w;
    endfunction

    function automatic beat_t mk_beat(input logic [31:0] d, input int idx, input logic last);
        beat_t bt;
        bt.data  = d;
        bt.first = ((idx % 16) == 0);
        bt.blk   = ((idx % 16) == 15);
        bt.msg   = last;
        return bt;
    endfunction

    // Sampled at negedge: inputs are steady and equal to what the next posedge sees.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            msg_bytes.delete();
            msg_words  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({out_data, out_first, out_blk_last, out_msg_last}),
                      64'(prev_out));
            end
            if (out_valid && out_ready) begin
                log_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_data), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_flags", 64'({out_first, out_blk_last, out_msg_last}),
                          64'({e.first, e.blk, e.msg}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_first, out_blk_last, out_msg_last};
            if (in_valid && in_ready) begin
                int nb;
                nb = !in_last ? 4 : ((in_bytes > 3'd4) ? 4 : int'(in_bytes));
                for (int k = 0; k < nb; k++) msg_bytes.push_back(in_data[31-8*k -: 8]);
                if (!in_last) begin
                    exp_q.push_back(mk_beat(in_data, msg_words, 1'b0));
                    msg_words++;
                end else begin
                    wq_t w;
                    w = pad_msg(msg_bytes);
                    for (int i = msg_words; i < w.size(); i++)
                        exp_q.push_back(mk_beat(w[i], i, i == w.size() - 1));
                    msg_bytes.delete();
                    msg_words = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Sends a message of nbytes; abort_at >= 0 pulses reset one cycle after that word.
    task automatic send_msg(input int nbytes, input int gap_pct, input int abort_at);
        int nwords;
        int rem;
        nwords = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            int  budget;
            logic acc;
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = (w == nwords - 1);
            rem      = nbytes - 4 * (nwords - 1);
            in_bytes = in_last ? 3'(rem) : 3'($urandom_range(0, 7));
            if (in_last && rem == 4 && $urandom_range(0, 1) == 1)
                in_bytes = 3'($urandom_range(4, 7));
            budget = 0;
            acc    = 1'b0;
            while (!acc && budget < 1000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) check("accept_timeout", 64'd0, 64'd1);
            if (w == abort_at) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_idle", 64'(exp_q.size() != 0 || busy), 64'd0);
    endtask

    task automatic check_abc(input string tag);
        check({tag, "_count"}, 64'(log_q.size()), 64'd16);
        if (log_q.size() == 16) begin
            check({tag, "_w0"}, 64'(log_q[0]), 64'h6162_6380);
            check({tag, "_w7"}, 64'(log_q[7]), 64'h0);
            check({tag, "_w14"}, 64'(log_q[14]), 64'h0);
            check({tag, "_w15"}, 64'(log_q[15]), 64'h18);
        end
    endtask

    task automatic send_abc();
        in_valid = 1'b1;
        in_data  = 32'h6162_6300;
        in_last  = 1'b1;
        in_bytes = 3'd3;
        do begin
            @(posedge clk);
            #1;
        end while (log_q.size() == 0 && exp_q.size() == 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        wq_t pin;
        bq_t empty;
        pin = pad_msg(empty);
        check("model_empty_w0", 64'(pin[0]), 64'h8000_0000);
        check("model_empty_len", 64'(pin.size()), 64'd16);

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_flags", 64'({out_first, out_blk_last, out_msg_last}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // T1 "abc"
        log_q.delete();
        send_abc();
        wait_idle();
        check_abc("t1");

        // T2 empty message
        log_q.delete();
        send_msg(0, 0, -1);
        wait_idle();
        check("t2_count", 64'(log_q.size()), 64'd16);
        if (log_q.size() == 16) begin
            check("t2_w0", 64'(log_q[0]), 64'h8000_0000);
            check("t2_w15", 64'(log_q[15]), 64'h0);
        end

        // T3 55 bytes
        log_q.delete();
        send_msg(55, 0, -1);
        wait_idle();
        check("t3_count", 64'(log_q.size()), 64'd16);
        if (log_q.size() == 16) begin
            check("t3_w13_lo", 64'(log_q[13][7:0]), 64'h80);
            check("t3_w14", 64'(log_q[14]), 64'h0);
            check("t3_w15", 64'(log_q[15]), 64'h1B8);
        end

        // T4 56 bytes spills into a second block
        log_q.delete();
        send_msg(56, 0, -1);
        wait_idle();
        check("t4_count", 64'(log_q.size()), 64'd32);
        if (log_q.size() == 32) begin
            check("t4_w14", 64'(log_q[14]), 64'h8000_0000);
            check("t4_w15", 64'(log_q[15]), 64'h0);
            check("t4_w30", 64'(log_q[30]), 64'h0);
            check("t4_w31", 64'(log_q[31]), 64'h1C0);
        end

        // T5 "abc" with random back-pressure
        ready_pct = 50;
        log_q.delete();
        send_abc();
        wait_idle();
        check_abc("t5");

        // T6 reset mid-message, then "abc"
        ready_pct = 100;
        send_msg(80, 0, 5);
        log_q.delete();
        send_abc();
        wait_idle();
        check_abc("t6");

        // Random messages, gaps and back-pressure
        for (int m = 0; m < 14; m++) begin
            ready_pct = $urandom_range(30, 100);
            send_msg($urandom_range(0, 140), $urandom_range(0, 30), -1);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
